// File: rtl/exe_stage.sv
// Execute stage of the 5-stage MIPS pipeline: ALU, HI/LO with a one-cycle
// multiplier and a 32-iteration restoring divider, and the data-SRAM request.
module exe_stage (
  input  logic         clk,
  input  logic         resetn,
  input  logic         ms_allowin,
  output logic         es_allowin,
  input  logic         ds_to_es_valid,
  input  logic [140:0] ds_to_es_bus,
  output logic         es_to_ms_valid,
  output logic [70:0]  es_to_ms_bus,
  output logic [38:0]  es_to_ds_bus,
  output logic         data_sram_en,
  output logic [3:0]   data_sram_wen,
  output logic [31:0]  data_sram_addr,
  output logic [31:0]  data_sram_wdata
);

  localparam logic [4:0] OP_ADD   = 5'd0;
  localparam logic [4:0] OP_SUB   = 5'd1;
  localparam logic [4:0] OP_SLT   = 5'd2;
  localparam logic [4:0] OP_SLTU  = 5'd3;
  localparam logic [4:0] OP_AND   = 5'd4;
  localparam logic [4:0] OP_OR    = 5'd5;
  localparam logic [4:0] OP_XOR   = 5'd6;
  localparam logic [4:0] OP_NOR   = 5'd7;
  localparam logic [4:0] OP_SLL   = 5'd8;
  localparam logic [4:0] OP_SRL   = 5'd9;
  localparam logic [4:0] OP_SRA   = 5'd10;
  localparam logic [4:0] OP_LUI   = 5'd11;
  localparam logic [4:0] OP_MULT  = 5'd12;
  localparam logic [4:0] OP_MULTU = 5'd13;
  localparam logic [4:0] OP_DIV   = 5'd14;
  localparam logic [4:0] OP_DIVU  = 5'd15;
  localparam logic [4:0] OP_MFHI  = 5'd16;
  localparam logic [4:0] OP_MFLO  = 5'd17;
  localparam logic [4:0] OP_MTHI  = 5'd18;
  localparam logic [4:0] OP_MTLO  = 5'd19;

  typedef enum logic [1:0] {
    DIV_IDLE = 2'd0,
    DIV_BUSY = 2'd1,
    DIV_DONE = 2'd2
  } div_state_e;

  logic         es_valid_q;
  logic [140:0] es_bus_q;
  logic [31:0]  hi_q, hi_d;
  logic [31:0]  lo_q, lo_d;
  div_state_e   div_state_q;
  logic [4:0]   div_cnt_q;
  logic [31:0]  div_quo_q;
  logic [31:0]  div_rem_q;
  logic [31:0]  div_dvsr_q;
  logic         div_qneg_q;
  logic         div_rneg_q;

  logic [4:0]   op_s;
  logic         res_from_mem_s;
  logic         mem_we_s;
  logic         gr_we_s;
  logic [4:0]   dest_s;
  logic [31:0]  src1_s;
  logic [31:0]  src2_s;
  logic [31:0]  store_data_s;
  logic [31:0]  pc_s;
  logic [31:0]  alu_result_s;
  logic         is_div_s;
  logic         div_signed_s;
  logic         mul_signed_s;
  logic [63:0]  mul_a_s;
  logic [63:0]  mul_b_s;
  logic [63:0]  mul_prod_s;
  logic [31:0]  div_abs1_s;
  logic [31:0]  div_abs2_s;
  logic [32:0]  div_shift_s;
  logic [32:0]  div_trial_s;
  logic [31:0]  div_quo_fix_s;
  logic [31:0]  div_rem_fix_s;
  logic         es_ready_go_s;
  logic         handoff_s;

  assign op_s           = es_bus_q[140:136];
  assign res_from_mem_s = es_bus_q[135];
  assign mem_we_s       = es_bus_q[134];
  assign gr_we_s        = es_bus_q[133];
  assign dest_s         = es_bus_q[132:128];
  assign src1_s         = es_bus_q[127:96];
  assign src2_s         = es_bus_q[95:64];
  assign store_data_s   = es_bus_q[63:32];
  assign pc_s           = es_bus_q[31:0];

  assign is_div_s      = (op_s == OP_DIV) || (op_s == OP_DIVU);
  assign es_ready_go_s = !(is_div_s && (div_state_q != DIV_DONE));
  assign handoff_s     = es_valid_q && es_ready_go_s && ms_allowin;

  assign es_allowin     = !es_valid_q || (es_ready_go_s && ms_allowin);
  assign es_to_ms_valid = es_valid_q && es_ready_go_s;
  assign es_to_ms_bus   = es_to_ms_valid ?
                          {res_from_mem_s, gr_we_s, dest_s, alu_result_s, pc_s} : 71'h0;
  assign es_to_ds_bus   = {es_valid_q && gr_we_s, dest_s, res_from_mem_s, alu_result_s};

  assign data_sram_en    = handoff_s && (res_from_mem_s || mem_we_s);
  assign data_sram_wen   = (handoff_s && mem_we_s) ? 4'hF : 4'h0;
  assign data_sram_addr  = alu_result_s;
  assign data_sram_wdata = store_data_s;

  // Sign-extending to 64 bits lets one unsigned multiplier serve MULT and MULTU.
  assign mul_signed_s = (op_s == OP_MULT);
  assign mul_a_s      = {{32{mul_signed_s & src1_s[31]}}, src1_s};
  assign mul_b_s      = {{32{mul_signed_s & src2_s[31]}}, src2_s};
  assign mul_prod_s   = mul_a_s * mul_b_s;

  assign div_signed_s = (op_s == OP_DIV);
  assign div_abs1_s   = (div_signed_s && src1_s[31]) ? (32'h0 - src1_s) : src1_s;
  assign div_abs2_s   = (div_signed_s && src2_s[31]) ? (32'h0 - src2_s) : src2_s;
  assign div_shift_s  = {div_rem_q, div_quo_q[31]};
  assign div_trial_s  = div_shift_s - {1'b0, div_dvsr_q};
  assign div_quo_fix_s = div_qneg_q ? (32'h0 - div_quo_q) : div_quo_q;
  assign div_rem_fix_s = div_rneg_q ? (32'h0 - div_rem_q) : div_rem_q;

  // ALU and HI/LO read result
  always_comb begin
    alu_result_s = 32'h0;
    case (op_s)
      OP_ADD:  alu_result_s = src1_s + src2_s;
      OP_SUB:  alu_result_s = src1_s - src2_s;
      OP_SLT:  alu_result_s = {31'h0, ($signed(src1_s) < $signed(src2_s))};
      OP_SLTU: alu_result_s = {31'h0, (src1_s < src2_s)};
      OP_AND:  alu_result_s = src1_s & src2_s;
      OP_OR:   alu_result_s = src1_s | src2_s;
      OP_XOR:  alu_result_s = src1_s ^ src2_s;
      OP_NOR:  alu_result_s = ~(src1_s | src2_s);
      OP_SLL:  alu_result_s = src2_s << src1_s[4:0];
      OP_SRL:  alu_result_s = src2_s >> src1_s[4:0];
      OP_SRA:  alu_result_s = $signed(src2_s) >>> src1_s[4:0];
      OP_LUI:  alu_result_s = {src2_s[15:0], 16'h0};
      OP_MFHI: alu_result_s = hi_q;
      OP_MFLO: alu_result_s = lo_q;
      default: alu_result_s = 32'h0;
    endcase
  end

  // HI/LO next state; only a handed-off instruction may commit
  always_comb begin
    hi_d = hi_q;
    lo_d = lo_q;
    if (handoff_s) begin
      case (op_s)
        OP_MULT, OP_MULTU: {hi_d, lo_d} = mul_prod_s;
        OP_DIV, OP_DIVU: begin
          hi_d = div_rem_fix_s;
          lo_d = div_quo_fix_s;
        end
        OP_MTHI: hi_d = src1_s;
        OP_MTLO: lo_d = src1_s;
        default: begin
          hi_d = hi_q;
          lo_d = lo_q;
        end
      endcase
    end else begin
      hi_d = hi_q;
      lo_d = lo_q;
    end
  end

  // Pipeline valid bit, instruction latch and HI/LO registers
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      es_valid_q <= 1'b0;
      es_bus_q   <= 141'h0;
      hi_q       <= 32'h0;
      lo_q       <= 32'h0;
    end else begin
      if (es_allowin) begin
        es_valid_q <= ds_to_es_valid;
      end
      if (ds_to_es_valid && es_allowin) begin
        es_bus_q <= ds_to_es_bus;
      end
      hi_q <= hi_d;
      lo_q <= lo_d;
    end
  end

  // Divider FSM: restoring division on magnitudes, sign fix-up applied on read
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      div_state_q <= DIV_IDLE;
      div_cnt_q   <= 5'd0;
      div_quo_q   <= 32'h0;
      div_rem_q   <= 32'h0;
      div_dvsr_q  <= 32'h0;
      div_qneg_q  <= 1'b0;
      div_rneg_q  <= 1'b0;
    end else begin
      case (div_state_q)
        DIV_IDLE: begin
          if (es_valid_q && is_div_s) begin
            div_state_q <= DIV_BUSY;
            div_cnt_q   <= 5'd0;
            div_quo_q   <= div_abs1_s;
            div_rem_q   <= 32'h0;
            div_dvsr_q  <= div_abs2_s;
            div_qneg_q  <= div_signed_s & (src1_s[31] ^ src2_s[31]);
            div_rneg_q  <= div_signed_s & src1_s[31];
          end
        end
        DIV_BUSY: begin
          div_quo_q <= {div_quo_q[30:0], ~div_trial_s[32]};
          div_rem_q <= div_trial_s[32] ? div_shift_s[31:0] : div_trial_s[31:0];
          div_cnt_q <= div_cnt_q + 5'd1;
          if (div_cnt_q == 5'd31) begin
            div_state_q <= DIV_DONE;
          end
        end
        DIV_DONE: begin
          if (handoff_s) begin
            div_state_q <= DIV_IDLE;
          end
        end
        default: div_state_q <= DIV_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_exe_stage.sv
// Directed self-checking bench for exe_stage with hand-computed expectations.
module tb_exe_stage;

  logic         clk;
  logic         resetn;
  logic         ms_allowin;
  logic         es_allowin;
  logic         ds_to_es_valid;
  logic [140:0] ds_to_es_bus;
  logic         es_to_ms_valid;
  logic [70:0]  es_to_ms_bus;
  logic [38:0]  es_to_ds_bus;
  logic         data_sram_en;
  logic [3:0]   data_sram_wen;
  logic [31:0]  data_sram_addr;
  logic [31:0]  data_sram_wdata;

  int checks_q;
  int errors_q;
  int lat;

  exe_stage dut (
    .clk             (clk),
    .resetn          (resetn),
    .ms_allowin      (ms_allowin),
    .es_allowin      (es_allowin),
    .ds_to_es_valid  (ds_to_es_valid),
    .ds_to_es_bus    (ds_to_es_bus),
    .es_to_ms_valid  (es_to_ms_valid),
    .es_to_ms_bus    (es_to_ms_bus),
    .es_to_ds_bus    (es_to_ds_bus),
    .data_sram_en    (data_sram_en),
    .data_sram_wen   (data_sram_wen),
    .data_sram_addr  (data_sram_addr),
    .data_sram_wdata (data_sram_wdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks_q++;
    if (got !== exp) begin
      errors_q++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [140:0] mk(input logic [4:0] op, input logic rfm, input logic mw,
                                      input logic gw, input logic [4:0] dst,
                                      input logic [31:0] s1, input logic [31:0] s2,
                                      input logic [31:0] sd, input logic [31:0] pc);
    return {op, rfm, mw, gw, dst, s1, s2, sd, pc};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [140:0] b);
    ds_to_es_valid = 1'b1;
    ds_to_es_bus   = b;
    step();
    ds_to_es_valid = 1'b0;
  endtask

  task automatic wait_valid(output int n);
    n = 0;
    while (!es_to_ms_valid && n < 40) begin
      step();
      n++;
    end
  endtask

  task automatic read_hilo(input string tag, input logic [31:0] hi_exp, input logic [31:0] lo_exp);
    ds_to_es_valid = 1'b1;
    ds_to_es_bus   = mk(5'd17, 1'b0, 1'b0, 1'b1, 5'd2, 32'h0, 32'h0, 32'h0, 32'h300);
    step();
    chk({tag, "_lo"}, es_to_ms_bus[63:32], lo_exp);
    ds_to_es_bus   = mk(5'd16, 1'b0, 1'b0, 1'b1, 5'd3, 32'h0, 32'h0, 32'h0, 32'h304);
    step();
    chk({tag, "_hi"}, es_to_ms_bus[63:32], hi_exp);
    ds_to_es_valid = 1'b0;
    step();
  endtask

  initial begin
    checks_q       = 0;
    errors_q       = 0;
    resetn         = 1'b0;
    ms_allowin     = 1'b1;
    ds_to_es_valid = 1'b0;
    ds_to_es_bus   = 141'h0;
    #12;
    chk("rst_allowin", es_allowin, 1'b1);
    chk("rst_valid", es_to_ms_valid, 1'b0);
    chk("rst_ms_bus", es_to_ms_bus, 71'h0);
    chk("rst_ds_bus", es_to_ds_bus, 39'h0);
    chk("rst_sram", {data_sram_en, data_sram_wen}, 5'h0);
    resetn = 1'b1;
    step();

    // back-to-back ALU ops
    ds_to_es_valid = 1'b1;
    ds_to_es_bus = mk(5'd0, 1'b0, 1'b0, 1'b1, 5'd5, 32'h7FFF_FFFF, 32'h1, 32'h0, 32'h1000);
    step();
    chk("add_valid", es_to_ms_valid, 1'b1);
    chk("add_bus", es_to_ms_bus, {1'b0, 1'b1, 5'd5, 32'h8000_0000, 32'h1000});
    chk("add_bypass", es_to_ds_bus, {1'b1, 5'd5, 1'b0, 32'h8000_0000});
    chk("add_noreq", data_sram_en, 1'b0);
    ds_to_es_bus = mk(5'd2, 1'b0, 1'b0, 1'b1, 5'd6, 32'hFFFF_FFFF, 32'h1, 32'h0, 32'h1004);
    step();
    chk("slt", es_to_ms_bus[63:32], 32'h1);
    ds_to_es_bus = mk(5'd3, 1'b0, 1'b0, 1'b1, 5'd6, 32'hFFFF_FFFF, 32'h1, 32'h0, 32'h1008);
    step();
    chk("sltu", es_to_ms_bus[63:32], 32'h0);
    ds_to_es_bus = mk(5'd10, 1'b0, 1'b0, 1'b1, 5'd7, 32'h4, 32'h8000_0000, 32'h0, 32'h100C);
    step();
    chk("sra", es_to_ms_bus[63:32], 32'hF800_0000);
    ds_to_es_bus = mk(5'd11, 1'b0, 1'b0, 1'b1, 5'd7, 32'h0, 32'h0000_1234, 32'h0, 32'h1010);
    step();
    chk("lui", es_to_ms_bus[63:32], 32'h1234_0000);

    // store then load
    ds_to_es_bus = mk(5'd0, 1'b0, 1'b1, 1'b0, 5'd0, 32'h100, 32'h4, 32'hDEAD_BEEF, 32'h1014);
    step();
    chk("sw_req", {data_sram_en, data_sram_wen}, {1'b1, 4'hF});
    chk("sw_addr", data_sram_addr, 32'h104);
    chk("sw_wdata", data_sram_wdata, 32'hDEAD_BEEF);
    ds_to_es_bus = mk(5'd0, 1'b1, 1'b0, 1'b1, 5'd8, 32'h100, 32'h4, 32'h0, 32'h1018);
    step();
    chk("lw_req", {data_sram_en, data_sram_wen}, {1'b1, 4'h0});
    chk("lw_rfm", es_to_ms_bus[70], 1'b1);
    chk("lw_load_bypass", es_to_ds_bus[32], 1'b1);
    ds_to_es_valid = 1'b0;
    step();
    chk("lw_once", data_sram_en, 1'b0);

    // multiply
    issue(mk(5'd12, 1'b0, 1'b0, 1'b0, 5'd0, 32'hFFFF_FFFD, 32'h5, 32'h0, 32'h2000));
    read_hilo("mult", 32'hFFFF_FFFF, 32'hFFFF_FFF1);
    issue(mk(5'd13, 1'b0, 1'b0, 1'b0, 5'd0, 32'hFFFF_FFFF, 32'h2, 32'h0, 32'h2004));
    read_hilo("multu", 32'h1, 32'hFFFF_FFFE);

    // divide
    issue(mk(5'd14, 1'b0, 1'b0, 1'b0, 5'd0, 32'hFFFF_FFF9, 32'h2, 32'h0, 32'h3000));
    chk("div_stall", es_allowin, 1'b0);
    wait_valid(lat);
    chk("div_latency", lat, 33);
    read_hilo("div", 32'hFFFF_FFFF, 32'hFFFF_FFFD);
    issue(mk(5'd15, 1'b0, 1'b0, 1'b0, 5'd0, 32'd100, 32'h0, 32'h0, 32'h3004));
    wait_valid(lat);
    chk("divu0_latency", lat, 33);
    read_hilo("divu0", 32'd100, 32'hFFFF_FFFF);
    issue(mk(5'd14, 1'b0, 1'b0, 1'b0, 5'd0, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 32'h3008));
    wait_valid(lat);
    read_hilo("divmin", 32'h0, 32'h8000_0000);

    // backpressure in DONE
    ms_allowin = 1'b0;
    issue(mk(5'd15, 1'b0, 1'b0, 1'b0, 5'd0, 32'd20, 32'd3, 32'h0, 32'h4000));
    wait_valid(lat);
    chk("bp_div_latency", lat, 33);
    for (int i = 0; i < 5; i++) begin
      step();
      chk("bp_div_bus", es_to_ms_bus, {1'b0, 1'b0, 5'd0, 32'h0, 32'h4000});
      chk("bp_div_hold", {es_to_ms_valid, es_allowin, data_sram_en}, 3'b100);
    end
    ms_allowin = 1'b1;
    read_hilo("bp_div", 32'd2, 32'd6);

    // backpressure on a store
    ms_allowin = 1'b0;
    issue(mk(5'd0, 1'b0, 1'b1, 1'b0, 5'd0, 32'h200, 32'h8, 32'h1234_5678, 32'h4004));
    for (int i = 0; i < 5; i++) begin
      chk("bp_sw_hold", {es_to_ms_valid, es_allowin, data_sram_en, data_sram_wen}, 7'b1000000);
      chk("bp_sw_bus", es_to_ms_bus, {1'b0, 1'b0, 5'd0, 32'h208, 32'h4004});
      step();
    end
    ms_allowin = 1'b1;
    #1;
    chk("bp_sw_release", {data_sram_en, data_sram_wen}, {1'b1, 4'hF});
    chk("bp_sw_addr", data_sram_addr, 32'h208);
    step();
    chk("bp_sw_once", data_sram_en, 1'b0);
    read_hilo("bp_sw", 32'd2, 32'd6);

    // reset in the middle of a division
    issue(mk(5'd15, 1'b0, 1'b0, 1'b1, 5'd9, 32'd50, 32'd7, 32'h0, 32'h5000));
    for (int i = 0; i < 11; i++) step();
    resetn = 1'b0;
    #1;
    chk("rstdiv_allowin", es_allowin, 1'b1);
    chk("rstdiv_outs", {es_to_ms_valid, es_to_ms_bus, es_to_ds_bus, data_sram_en, data_sram_wen},
        116'h0);
    step();
    resetn = 1'b1;
    step();
    read_hilo("rstdiv", 32'h0, 32'h0);
    issue(mk(5'd15, 1'b0, 1'b0, 1'b0, 5'd0, 32'd9, 32'd3, 32'h0, 32'h5004));
    wait_valid(lat);
    chk("divu93_latency", lat, 33);
    read_hilo("divu93", 32'h0, 32'h3);

    $display("CHECKS %0d ERRORS %0d", checks_q, errors_q);
    $finish;
  end

endmodule
